// File: rtl/tick_src_select.sv
// Glitch-free selector for the oven timing sources: synchronises N_SRC level inputs,
// defers a source change until the output is low, then holds a low guard interval.
module tick_src_select #(
  parameter int N_SRC       = 4,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int GUARD_CYC   = 3,
  parameter int CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [SEL_W-1:0] sel,
  input  logic             clear,
  output logic             out,
  output logic             out_rise,
  output logic [SEL_W-1:0] active_sel,
  output logic             switching,
  output logic             sel_err,
  output logic [CNT_W-1:0] rise_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  localparam int GW = (GUARD_CYC > 2) ? $clog2(GUARD_CYC) : 1;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] syncd;
  logic             sel_bit;
  logic             sel_valid;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign syncd     = sync_q[SYNC_STAGES-1];
  assign sel_bit   = syncd[active_q];
  assign sel_valid = (32'(sel) < 32'(N_SRC));

  // Synchroniser chain, one shift register per source bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // State, selection, output and diagnostic registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      target_q <= '0;
      active_q <= '0;
      gcnt_q   <= '0;
      out_q    <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      active_q <= active_d;
      gcnt_q   <= gcnt_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; a switch only commits once the registered output is low
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    active_d = active_q;
    gcnt_d   = gcnt_q;
    out_d    = out_q;
    case (state_q)
      ST_RUN: begin
        out_d = sel_bit;
        if (sel_valid && (sel != active_q)) begin
          target_d = sel;
          state_d  = ST_PEND;
        end else begin
          state_d  = ST_RUN;
        end
      end
      ST_PEND: begin
        out_d = sel_bit;
        if (sel_valid) begin
          target_d = sel;
        end else begin
          target_d = target_q;
        end
        if (sel_valid && (sel == active_q)) begin
          state_d = ST_RUN;
        end else if (!out_q) begin
          active_d = target_d;
          out_d    = 1'b0;
          if (GUARD_CYC == 0) begin
            state_d = ST_RUN;
          end else begin
            gcnt_d  = GW'(GUARD_CYC - 1);
            state_d = ST_GUARD;
          end
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_GUARD: begin
        out_d = 1'b0;
        if (gcnt_q == GW'(0)) begin
          state_d = ST_RUN;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        out_d   = 1'b0;
      end
    endcase

    rise_d = out_d & ~out_q;

    if (clear) begin
      cnt_d = '0;
    end else if (rise_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (!sel_valid) begin
      err_d = 1'b1;
    end else if (clear) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign out        = out_q;
  assign out_rise   = rise_q;
  assign active_sel = active_q;
  assign switching  = (state_q != ST_RUN);
  assign sel_err    = err_q;
  assign rise_count = cnt_q;

endmodule

// File: tb/tb_tick_src_select.sv
// Self-checking bench for tick_src_select: directed table, corner-case sequences and
// randomized traffic compared against a cycle-level behavioural model.
module tb_tick_src_select;

  localparam int N  = 3;
  localparam int S  = 2;
  localparam int G  = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  src;
  logic [1:0]    sel;
  logic          clear;
  logic          dut_out, dut_rise, dut_sw, dut_err;
  logic [1:0]    dut_act;
  logic [CW-1:0] dut_cnt;

  int checks   = 0;
  int failures = 0;

  // model state: pending request flag plus remaining forced-low cycles
  logic [N-1:0] m_hist [S];
  bit m_out, m_rise, m_pend, m_err;
  int m_guard, m_act, m_tgt, m_cnt;

  typedef struct {
    logic [N-1:0] src;
    logic [1:0]   sel;
    logic         clear;
    logic         out;
    logic         rise;
    logic [1:0]   act;
    logic         sw;
    int           cnt;
  } vec_t;
  vec_t vec [1:16];

  tick_src_select #(
    .N_SRC(N), .SEL_W(2), .SYNC_STAGES(S), .GUARD_CYC(G), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .src(src), .sel(sel), .clear(clear),
    .out(dut_out), .out_rise(dut_rise), .active_sel(dut_act),
    .switching(dut_sw), .sel_err(dut_err), .rise_count(dut_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_hist[i] = '0;
    m_out = 0; m_rise = 0; m_pend = 0; m_err = 0;
    m_guard = 0; m_act = 0; m_tgt = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] syn;
    bit valid, nout;
    syn   = m_hist[S-1];
    valid = (int'(sel) < N);
    if (m_guard > 0) begin
      nout = 0;
      m_guard--;
    end else if (m_pend) begin
      nout = syn[m_act];
      if (valid) m_tgt = int'(sel);
      if (valid && int'(sel) == m_act) begin
        m_pend = 0;
      end else if (!m_out) begin
        m_act   = m_tgt;
        nout    = 0;
        m_pend  = 0;
        m_guard = G;
      end
    end else begin
      nout = syn[m_act];
      if (valid && int'(sel) != m_act) begin
        m_tgt  = int'(sel);
        m_pend = 1;
      end
    end
    m_rise = nout && !m_out;
    m_out  = nout;
    if (clear) m_cnt = 0;
    else if (m_rise && m_cnt < CMAX) m_cnt++;
    if (!valid) m_err = 1;
    else if (clear) m_err = 0;
    for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = src;
  endtask

  task automatic compare_model();
    chk("model_out", dut_out, m_out);
    chk("model_rise", dut_rise, m_rise);
    chk("model_active", dut_act, m_act);
    chk("model_switching", dut_sw, (m_pend || m_guard > 0));
    chk("model_sel_err", dut_err, m_err);
    chk("model_rise_count", dut_cnt, m_cnt);
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  initial begin
    // directed table: src[0] rises in the cycle after edge 10
    for (int r = 1; r <= 16; r++) begin
      vec[r] = '{src: 3'b000, sel: 2'd0, clear: 1'b0, out: 1'b0, rise: 1'b0,
                 act: 2'd0, sw: 1'b0, cnt: 0};
      if (r >= 11) vec[r].src = 3'b001;
      if (r >= 13) begin vec[r].out = 1'b1; vec[r].cnt = 1; end
      if (r == 13) vec[r].rise = 1'b1;
    end

    reset = 1'b1; src = '0; sel = 2'd0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out", dut_out, 1'b0);
    chk("reset_rise", dut_rise, 1'b0);
    chk("reset_active", dut_act, 2'd0);
    chk("reset_switching", dut_sw, 1'b0);
    chk("reset_sel_err", dut_err, 1'b0);
    chk("reset_rise_count", dut_cnt, 0);
    reset = 1'b0;

    for (int r = 1; r <= 16; r++) begin
      src = vec[r].src; sel = vec[r].sel; clear = vec[r].clear;
      step();
      chk("tbl_out", dut_out, vec[r].out);
      chk("tbl_rise", dut_rise, vec[r].rise);
      chk("tbl_active", dut_act, vec[r].act);
      chk("tbl_switching", dut_sw, vec[r].sw);
      chk("tbl_rise_count", dut_cnt, vec[r].cnt);
    end

    // abort: request source 2 while out is high, then return to 0
    sel = 2'd2; step();
    chk("abort_pend_sw", dut_sw, 1'b1);
    step();
    sel = 2'd0; step();
    chk("abort_sw", dut_sw, 1'b0);
    chk("abort_active", dut_act, 2'd0);
    chk("abort_out", dut_out, 1'b1);

    // mid-pulse switch to source 2: pulse not truncated, guard low, no rise in guard
    src = 3'b101; sel = 2'd2; step();
    chk("sw_pend", dut_sw, 1'b1);
    repeat (10) step();
    chk("sw_hold_out", dut_out, 1'b1);
    src = 3'b100;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k <= 1) chk("sw_pulse_kept", dut_out, 1'b1);
      if (k >= 2 && k <= 6) begin
        chk("sw_low", dut_out, 1'b0);
        chk("sw_no_rise", dut_rise, 1'b0);
      end
      if (k == 3) chk("sw_active", dut_act, 2'd2);
      if (k == 5) chk("sw_guard_busy", dut_sw, 1'b1);
      if (k == 6) chk("sw_guard_done", dut_sw, 1'b0);
      if (k == 7) begin
        chk("sw_new_out", dut_out, 1'b1);
        chk("sw_new_rise", dut_rise, 1'b1);
      end
    end

    // invalid select (3 with three sources)
    sel = 2'd3; step();
    chk("err_set", dut_err, 1'b1);
    chk("err_active", dut_act, 2'd2);
    chk("err_sw", dut_sw, 1'b0);
    clear = 1'b1; step();
    chk("err_set_wins", dut_err, 1'b1);
    sel = 2'd2; step();
    chk("err_cleared", dut_err, 1'b0);
    chk("clear_count", dut_cnt, 0);
    clear = 1'b0;

    // move to source 1 with all sources low
    src = '0; sel = 2'd1;
    for (int k = 0; k < 20 && !(dut_act == 2'd1 && !dut_sw); k++) step();
    chk("to_src1_active", dut_act, 2'd1);
    chk("to_src1_settled", dut_sw, 1'b0);

    // saturation: 20 pulses on source 1
    for (int p = 0; p < 20; p++) begin
      src = 3'b010; repeat (2) step();
      src = 3'b000; repeat (2) step();
    end
    repeat (4) step();
    chk("sat_count", dut_cnt, CMAX);

    // clear in the same cycle as a rise: clear wins
    src = 3'b010; step(); step();
    clear = 1'b1; step();
    chk("clr_rise_pulse", dut_rise, 1'b1);
    chk("clr_rise_count", dut_cnt, 0);
    clear = 1'b0; src = 3'b000;
    repeat (4) step();

    // reset asserted during guard
    sel = 2'd0; step(); step();
    chk("guard_entered", dut_sw, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_guard_out", dut_out, 1'b0);
    chk("rst_guard_active", dut_act, 2'd0);
    chk("rst_guard_sw", dut_sw, 1'b0);
    chk("rst_guard_cnt", dut_cnt, 0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    src = 3'b001;
    repeat (4) step();
    chk("post_rst_out", dut_out, 1'b1);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) src[b] = ~src[b];
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      clear = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
